// File: rtl/dot_accum_stage_if.sv
// dot_accum_stage_if: partial-sum input and final-sum output bundle between adder tree and comb stage
interface dot_accum_stage_if #(
    parameter int bitwidth = 32
);
    logic [bitwidth-1:0] psum_in;
    logic                psum_valid;
    logic                flush;
    logic [bitwidth-1:0] data_out;
    logic                valid;
    logic                ovf;
    logic                busy;

    modport master (
        output psum_in, psum_valid, flush,
        input  data_out, valid, ovf, busy
    );

    modport slave (
        input  psum_in, psum_valid, flush,
        output data_out, valid, ovf, busy
    );
endinterface

// File: rtl/dot_accum_stage.sv
// dot_accum_stage: saturating accumulation of NUM_CHUNKS signed partial sums into one pulsed result
module dot_accum_stage #(
    parameter int bitwidth   = 32,
    parameter int NUM_CHUNKS = 4
) (
    input logic              clk,
    input logic              rst_n,
    dot_accum_stage_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_CHUNKS) + 1;
    localparam logic [bitwidth-1:0] SAT_MAX = {1'b0, {(bitwidth-1){1'b1}}};
    localparam logic [bitwidth-1:0] SAT_MIN = {1'b1, {(bitwidth-1){1'b0}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t              state, state_nxt;
    logic [bitwidth-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                ovf_acc, ovf_acc_nxt;
    logic [bitwidth:0]   sum;
    logic [bitwidth-1:0] sat;
    logic                sat_hit, take, last, sticky, clear;

    // acc is zero in IDLE, so the first chunk goes through the same adder unchanged
    always_comb begin
        sum         = {acc[bitwidth-1], acc} + {bus.psum_in[bitwidth-1], bus.psum_in};
        sat_hit     = sum[bitwidth] != sum[bitwidth-1];
        sat         = sat_hit ? (sum[bitwidth] ? SAT_MIN : SAT_MAX) : sum[bitwidth-1:0];
        take        = bus.psum_valid & ~bus.flush;
        last        = take & (cnt == CNT_W'(NUM_CHUNKS - 1));
        sticky      = ((state == ACCUM) & ovf_acc) | sat_hit;
        clear       = bus.flush | last;
        state_nxt   = clear ? IDLE : take ? ACCUM : state;
        acc_nxt     = clear ? '0 : take ? sat : acc;
        cnt_nxt     = clear ? '0 : take ? cnt + CNT_W'(1) : cnt;
        ovf_acc_nxt = clear ? 1'b0 : take ? sticky : ovf_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            ovf_acc      <= 1'b0;
            bus.data_out <= '0;
            bus.valid    <= 1'b0;
            bus.ovf      <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            ovf_acc   <= ovf_acc_nxt;
            bus.valid <= last;
            if (last) begin
                bus.data_out <= sat;
                bus.ovf      <= sticky;
            end
        end
    end

    assign bus.busy = state == ACCUM;
endmodule

// File: tb/tb_dot_accum_stage.sv
// tb_dot_accum_stage: directed vector table, async-reset corner and randomized run against a list-based model
module tb_dot_accum_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dot_accum_stage_if #(.bitwidth(32)) bus ();
    dot_accum_stage_if #(.bitwidth(32)) bus1 ();

    dot_accum_stage #(.bitwidth(32), .NUM_CHUNKS(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    dot_accum_stage #(.bitwidth(32), .NUM_CHUNKS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int total = 0;
    int bad = 0;

    typedef struct {
        bit          pv;
        bit          fl;
        logic [31:0] ps;
        bit          ev;
        logic [31:0] ed;
        bit          eo;
        bit          eb;
    } vec_t;
    vec_t tv[$];

    longint      q[$];
    logic [31:0] m_data = '0;
    bit          m_ovf = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] e1_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step(input bit pv, input bit fl, input logic [31:0] ps);
        bus.psum_valid = pv;
        bus.flush      = fl;
        bus.psum_in    = ps;
        @(posedge clk);
        #1;
    endtask

    // Sample = list of chunks; the sum is a running clamp over the list, evaluated when the list is full
    task automatic model(input bit pv, input bit fl, input logic [31:0] ps);
        longint s;
        bit     o;
        m_valid = 1'b0;
        if (fl) q.delete();
        else if (pv) begin
            q.push_back(longint'($signed(ps)));
            if (q.size() == 4) begin
                s = 0;
                o = 1'b0;
                foreach (q[i]) begin
                    s += q[i];
                    if (s > 64'sd2147483647) begin s = 64'sd2147483647; o = 1'b1; end
                    else if (s < -64'sd2147483648) begin s = -64'sd2147483648; o = 1'b1; end
                end
                m_data  = s[31:0];
                m_ovf   = o;
                m_valid = 1'b1;
                q.delete();
            end
        end
    endtask

    initial begin
        bus.psum_valid = 1'b0; bus.flush = 1'b0; bus.psum_in = '0;
        bus1.psum_valid = 1'b0; bus1.flush = 1'b0; bus1.psum_in = '0;

        // basic 10,-3,7,100
        tv.push_back('{1, 0, 32'd10,         0, 32'd0,   0, 1});
        tv.push_back('{1, 0, 32'hFFFFFFFD,   0, 32'd0,   0, 1});
        tv.push_back('{1, 0, 32'd7,          0, 32'd0,   0, 1});
        tv.push_back('{1, 0, 32'd100,        1, 32'd114, 0, 0});
        tv.push_back('{0, 0, 32'd0,          0, 32'd114, 0, 0});
        // gaps then back-to-back
        tv.push_back('{1, 0, 32'd1,          0, 32'd114, 0, 1});
        tv.push_back('{1, 0, 32'd2,          0, 32'd114, 0, 1});
        tv.push_back('{0, 0, 32'd77,         0, 32'd114, 0, 1});
        tv.push_back('{0, 0, 32'd77,         0, 32'd114, 0, 1});
        tv.push_back('{0, 0, 32'd77,         0, 32'd114, 0, 1});
        tv.push_back('{1, 0, 32'd3,          0, 32'd114, 0, 1});
        tv.push_back('{1, 0, 32'd4,          1, 32'd10,  0, 0});
        tv.push_back('{1, 0, 32'd5,          0, 32'd10,  0, 1});
        tv.push_back('{1, 0, 32'd5,          0, 32'd10,  0, 1});
        tv.push_back('{1, 0, 32'd5,          0, 32'd10,  0, 1});
        tv.push_back('{1, 0, 32'd5,          1, 32'd20,  0, 0});
        tv.push_back('{0, 0, 32'd0,          0, 32'd20,  0, 0});
        // positive saturation, then clean sample clears ovf
        tv.push_back('{1, 0, 32'h7FFFFFF0,   0, 32'd20,  0, 1});
        tv.push_back('{1, 0, 32'h00000100,   0, 32'd20,  0, 1});
        tv.push_back('{1, 0, 32'hFFFFFFF0,   0, 32'd20,  0, 1});
        tv.push_back('{1, 0, 32'd0,          1, 32'h7FFFFFEF, 1, 0});
        tv.push_back('{0, 0, 32'd0,          0, 32'h7FFFFFEF, 1, 0});
        tv.push_back('{1, 0, 32'd1,          0, 32'h7FFFFFEF, 1, 1});
        tv.push_back('{1, 0, 32'd1,          0, 32'h7FFFFFEF, 1, 1});
        tv.push_back('{1, 0, 32'd1,          0, 32'h7FFFFFEF, 1, 1});
        tv.push_back('{1, 0, 32'd1,          1, 32'd4,   0, 0});
        // negative saturation
        tv.push_back('{1, 0, 32'h80000000,   0, 32'd4,   0, 1});
        tv.push_back('{1, 0, 32'hFFFFFFFF,   0, 32'd4,   0, 1});
        tv.push_back('{1, 0, 32'd1,          0, 32'd4,   0, 1});
        tv.push_back('{1, 0, 32'd0,          1, 32'h80000001, 1, 0});
        // flush on the final chunk, then flush while idle
        tv.push_back('{1, 0, 32'd1,          0, 32'h80000001, 1, 1});
        tv.push_back('{1, 0, 32'd2,          0, 32'h80000001, 1, 1});
        tv.push_back('{1, 0, 32'd3,          0, 32'h80000001, 1, 1});
        tv.push_back('{1, 1, 32'd9,          0, 32'h80000001, 1, 0});
        tv.push_back('{0, 1, 32'd0,          0, 32'h80000001, 1, 0});
        tv.push_back('{1, 1, 32'd5,          0, 32'h80000001, 1, 0});
        tv.push_back('{1, 0, 32'd2,          0, 32'h80000001, 1, 1});
        tv.push_back('{1, 0, 32'd2,          0, 32'h80000001, 1, 1});
        tv.push_back('{1, 0, 32'd2,          0, 32'h80000001, 1, 1});
        tv.push_back('{1, 0, 32'd2,          1, 32'd8,   0, 0});
        tv.push_back('{0, 0, 32'd0,          0, 32'd8,   0, 0});

        // reset held with psum_valid asserted
        bus.psum_valid = 1'b1; bus.psum_in = 32'd55;
        repeat (3) @(posedge clk);
        #1;
        check("rst valid", {31'd0, bus.valid}, 32'd0);
        check("rst data",  bus.data_out, 32'd0);
        check("rst ovf",   {31'd0, bus.ovf}, 32'd0);
        check("rst busy",  {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            step(tv[i].pv, tv[i].fl, tv[i].ps);
            check($sformatf("tv%0d valid", i), {31'd0, bus.valid}, {31'd0, tv[i].ev});
            check($sformatf("tv%0d data", i),  bus.data_out, tv[i].ed);
            check($sformatf("tv%0d ovf", i),   {31'd0, bus.ovf}, {31'd0, tv[i].eo});
            check($sformatf("tv%0d busy", i),  {31'd0, bus.busy}, {31'd0, tv[i].eb});
        end

        // async reset after two chunks clears outputs without waiting for a clock
        step(1, 0, 32'd3);
        step(1, 0, 32'd4);
        check("pre-arst busy", {31'd0, bus.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst data",  bus.data_out, 32'd0);
        check("arst valid", {31'd0, bus.valid}, 32'd0);
        check("arst ovf",   {31'd0, bus.ovf}, 32'd0);
        check("arst busy",  {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        m_data = '0;
        m_ovf = 1'b0;

        for (int n = 0; n < 800; n++) begin
            bit          pv, fl, pv1, fl1;
            logic [31:0] ps, ps1;
            pv  = ($urandom % 10) < 7;
            fl  = ($urandom % 20) == 0;
            ps  = ($urandom % 3 == 0) ? $urandom : $urandom_range(2000) - 32'd1000;
            pv1 = ($urandom % 10) < 6;
            fl1 = ($urandom % 8) == 0;
            ps1 = $urandom;
            bus1.psum_valid = pv1;
            bus1.flush      = fl1;
            bus1.psum_in    = ps1;
            step(pv, fl, ps);
            model(pv, fl, ps);
            if (pv1 && !fl1) e1_data = ps1;
            check("rnd valid", {31'd0, bus.valid}, {31'd0, m_valid});
            check("rnd data",  bus.data_out, m_data);
            check("rnd ovf",   {31'd0, bus.ovf}, {31'd0, m_ovf});
            check("rnd busy",  {31'd0, bus.busy}, {31'd0, q.size() != 0});
            check("n1 valid",  {31'd0, bus1.valid}, {31'd0, pv1 && !fl1});
            check("n1 data",   bus1.data_out, e1_data);
            check("n1 ovf",    {31'd0, bus1.ovf}, 32'd0);
            check("n1 busy",   {31'd0, bus1.busy}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
